// File: rtl/mux_out_fifo.sv
// Clocked receive stage for the 1-bit CSP mux channel: four-phase req/ack in, DEPTH-entry FIFO, valid/ready out.
// Optional build macro MUX_FIFO_COUNT_EN adds fill_count and overflow_seen observation ports.
module mux_out_fifo #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_req,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready
`ifdef MUX_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow_seen
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE = 1'b0, ACKD = 1'b1} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] req_p;
    logic                 req_s;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 push;
    logic                 pop;

    // in_req crosses into clk here; in_data is bundled and only sampled once req_s is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_p <= '0;
        end else begin
            req_p <= {req_p[SYNC_STAGES-2:0], in_req};
        end
    end

    assign req_s = req_p[SYNC_STAGES-1];
    assign full  = (count == CW'(DEPTH));
    // push decides on the registered count, so a pop on a full FIFO cannot be bypassed the same edge
    assign push  = (state == IDLE) && req_s && !full;
    assign pop   = (count != '0) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            in_ack <= 1'b0;
            wptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        wptr   <= wptr + AW'(1);
                        in_ack <= 1'b1;
                        state  <= ACKD;
                    end
                end
                ACKD: begin
                    if (!req_s) begin
                        in_ack <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    in_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rptr] : '0;

`ifdef MUX_FIFO_COUNT_EN
    assign fill_count = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_seen <= 1'b0;
        end else if ((state == IDLE) && req_s && full) begin
            overflow_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_out_fifo.sv
// Scoreboard bench for mux_out_fifo: handshake driver queues expected tokens, a negedge monitor checks every pop.
module tb_mux_out_fifo;
    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_req = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ack;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
`ifdef MUX_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] fill_count;
    logic                   overflow_seen;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int valid_cycles = 0;
    bit rand_mode = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    mux_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef MUX_FIFO_COUNT_EN
        , .fill_count(fill_count), .overflow_seen(overflow_seen)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every accepted output is compared with the oldest expected token
    always @(negedge clk) begin
        if (reset && out_valid) begin
            valid_cycles++;
            if (out_ready) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pop actual=%0d expected=none (t=%0t)", out_data, $time);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL pop_data actual=%0d expected=%0d (t=%0t)", out_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output int lat);
        int start;
        start = cyc;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (in_ack === lvl) begin
                lat = cyc - start;
                return;
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit chk_lat);
        int lat;
        in_data = d;
        in_req = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, 60, lat);
        if (chk_lat) chk("ack_rise_latency", lat, LAT);
        else         chk("ack_rise_seen", int'(lat > 0), 1);
        in_req = 1'b0;
        wait_ack(1'b0, 60, lat);
        chk("ack_fall_latency", lat, LAT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, v0, lat;
        logic [WIDTH-1:0] stream [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset state
        #10 reset = 1'b1;
        tick(3);
        chk("reset_in_ack", in_ack, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);

        // single token, valid shown for exactly one clock
        out_ready = 1'b1;
        v0 = valid_cycles;
        p0 = pops;
        send(1'b1, 1'b1);
        tick(3);
        chk("single_valid_cycles", valid_cycles - v0, 1);
        chk("single_pops", pops - p0, 1);

        // fill to DEPTH, fifth token is back-pressured
        out_ready = 1'b0;
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        in_data = 1'b1;
        in_req = 1'b1;
        exp_q.push_back(1'b1);
        tick(10);
        chk("full_no_ack", in_ack, 0);
        chk("full_out_data_head", out_data, 0);
`ifdef MUX_FIFO_COUNT_EN
        chk("full_fill_count", fill_count, DEPTH);
        chk("full_overflow_seen", overflow_seen, 1);
`endif
        out_ready = 1'b1;
        wait_ack(1'b1, 60, lat);
        chk("full_late_ack_seen", int'(lat > 0), 1);
        in_req = 1'b0;
        wait_ack(1'b0, 60, lat);
        chk("full_late_ack_fall", lat, LAT);
        tick(8);
        chk("full_drained", exp_q.size(), 0);

        // streaming with wrap
        p0 = pops;
        for (int i = 0; i < 8; i++) send(stream[i], 1'b1);
        tick(4);
        chk("stream_pops", pops - p0, 8);

        // simultaneous push and pop at count=2
        out_ready = 1'b0;
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        in_data = 1'b1;
        in_req = 1'b1;
        exp_q.push_back(1'b1);
        tick(SYNC);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pushpop_ack", in_ack, 1);
`ifdef MUX_FIFO_COUNT_EN
        chk("pushpop_fill_count", fill_count, 2);
`endif
        in_req = 1'b0;
        wait_ack(1'b0, 60, lat);
        chk("pushpop_ack_fall", lat, LAT);
        p0 = pops;
        out_ready = 1'b1;
        tick(6);
        chk("pushpop_remaining", pops - p0, 2);

        // randomized data with random back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) send(WIDTH'($urandom_range(0, 1)), 1'b0);
        rand_mode = 1'b0;
        tick(1);
        out_ready = 1'b1;
        tick(10);
        chk("random_drained", exp_q.size(), 0);

        // reset mid-handshake
        out_ready = 1'b0;
        in_data = 1'b1;
        in_req = 1'b1;
        exp_q.push_back(1'b1);
        wait_ack(1'b1, 60, lat);
        chk("pre_reset_ack_latency", lat, LAT);
        chk("pre_reset_valid", out_valid, 1);
        #3 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_async_in_ack", in_ack, 0);
        chk("reset_async_out_valid", out_valid, 0);
        tick(2);
        reset = 1'b1;
        exp_q.push_back(1'b1);
        wait_ack(1'b1, 60, lat);
        chk("post_reset_ack_latency", lat, LAT);
        tick(10);
`ifdef MUX_FIFO_COUNT_EN
        chk("post_reset_fill_count", fill_count, 1);
        chk("post_reset_overflow", overflow_seen, 0);
`endif
        p0 = pops;
        out_ready = 1'b1;
        tick(5);
        chk("post_reset_single_push", pops - p0, 1);
        in_req = 1'b0;
        wait_ack(1'b0, 60, lat);
        chk("post_reset_ack_fall", lat, LAT);
        tick(3);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
